bnn_layer_sequencer: RTL and testbench

BNN_LAYER_SEQUENCER -- requirements
Module: bnn_layer_sequencer

---
 rtl/bnn_pkg.sv | 43 ++++
 rtl/bnn_phase_timer.sv | 50 +++++
 rtl/bnn_layer_sequencer.sv | 149 ++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared BNN layer-state and sub-phase codes
package bnn_pkg;

    localparam int CNT_W   = 16;
    localparam int DRAIN_W = 4;

    typedef enum logic [2:0] {
        LAYER_IDLE  = 3'b000,
        LAYER_READ  = 3'b001,
        LAYER_CONV1 = 3'b010,
        LAYER_CONV2 = 3'b011,
        LAYER_CONV3 = 3'b100,
        LAYER_FCL1  = 3'b101,
        LAYER_FCL2  = 3'b110
    } layer_e;

    typedef enum logic [1:0] {
        PHASE_GAP   = 2'b00,
        PHASE_RUN   = 2'b01,
        PHASE_DRAIN = 2'b10
    } phase_e;

    // Layers that run the GAP/RUN/DRAIN sub-phase sequence.
    function automatic logic is_compute_layer(input layer_e s);
        return (s inside {LAYER_CONV1, LAYER_CONV2, LAYER_CONV3, LAYER_FCL1, LAYER_FCL2});
    endfunction

    // Any state that counts toward the per-layer timeout.
    function automatic logic is_active(input layer_e s);
        return (s == LAYER_READ) || is_compute_layer(s);
    endfunction

    function automatic layer_e next_layer(input layer_e s);
        case (s)
            LAYER_CONV1: return LAYER_CONV2;
            LAYER_CONV2: return LAYER_CONV3;
            LAYER_CONV3: return LAYER_FCL1;
            LAYER_FCL1:  return LAYER_FCL2;
            default:     return LAYER_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bnn_phase_timer.sv
// rtl/bnn_phase_timer.sv - per-layer timeout counter and drain counter
module bnn_phase_timer
    import bnn_pkg::*;
#(
    parameter int                PIPE_DRAIN = 4,
    parameter logic [CNT_W-1:0]  TIMEOUT    = 16'd40000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_layer_load,
    input  logic i_layer_count,
    input  logic i_drain_load,
    input  logic i_drain_count,
    output logic o_layer_tc,
    output logic o_drain_tc
);

    // Terminal values mark the last cycle of a layer budget / drain window.
    localparam logic [CNT_W-1:0]   LAYER_LAST = TIMEOUT - CNT_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DRAIN - 1);

    logic [CNT_W-1:0]   r_layer_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;

    // Layer cycle counter: cleared on layer entry, saturating increment.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_layer_cnt <= '0;
        end else if (i_layer_load) begin
            r_layer_cnt <= '0;
        end else if (i_layer_count && (r_layer_cnt != '1)) begin
            r_layer_cnt <= r_layer_cnt + CNT_W'(1);
        end
    end

    // Drain counter: cleared on DRAIN entry, saturating increment.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_drain_cnt <= '0;
        end else if (i_drain_load) begin
            r_drain_cnt <= '0;
        end else if (i_drain_count && (r_drain_cnt != '1)) begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        end
    end

    assign o_layer_tc = (r_layer_cnt == LAYER_LAST);
    assign o_drain_tc = (r_drain_cnt == DRAIN_LAST);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// rtl/bnn_layer_sequencer.sv - BNN layer FSM with GAP/RUN/DRAIN sub-phases
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int               PIPE_DRAIN = 4,
    parameter logic [CNT_W-1:0] TIMEOUT    = 16'd40000
) (
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic       iSTART,
    input  logic       iABORT,
    input  logic       iLOAD_DONE,
    input  logic       iRd_DONE,
    output logic [2:0] oSTATE,
    output logic       oRd_EN,
    output logic       oLAYER_START,
    output logic       oBUSY,
    output logic       oDONE,
    output logic       oERR
);

    layer_e r_state;
    layer_e w_nstate;
    phase_e r_phase;
    phase_e w_nphase;

    logic r_rd_en;
    logic r_layer_start;
    logic r_busy;
    logic r_done;
    logic r_err;

    logic w_done;
    logic w_err;
    logic w_layer_load;
    logic w_drain_load;
    logic w_active;
    logic w_layer_tc;
    logic w_drain_tc;

    assign w_active = is_active(r_state);

    bnn_phase_timer #(
        .PIPE_DRAIN (PIPE_DRAIN),
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .i_clk         (iCLK),
        .i_rstn        (iRSTn),
        .i_layer_load  (w_layer_load),
        .i_layer_count (w_active),
        .i_drain_load  (w_drain_load),
        .i_drain_count (is_compute_layer(r_state) && (r_phase == PHASE_DRAIN)),
        .o_layer_tc    (w_layer_tc),
        .o_drain_tc    (w_drain_tc)
    );

    // Next-state decode: abort beats timeout, timeout beats normal progress.
    always_comb begin
        w_nstate     = r_state;
        w_nphase     = r_phase;
        w_done       = 1'b0;
        w_err        = r_err;
        w_layer_load = 1'b0;
        w_drain_load = 1'b0;
        if (w_active && iABORT) begin
            w_nstate = LAYER_IDLE;
            w_nphase = PHASE_GAP;
        end else if (w_active && w_layer_tc) begin
            w_nstate = LAYER_IDLE;
            w_nphase = PHASE_GAP;
            w_err    = 1'b1;
        end else begin
            case (r_state)
                LAYER_IDLE: begin
                    if (iSTART && !iABORT) begin
                        w_nstate     = LAYER_READ;
                        w_nphase     = PHASE_GAP;
                        w_err        = 1'b0;
                        w_layer_load = 1'b1;
                    end
                end
                LAYER_READ: begin
                    if (iLOAD_DONE) begin
                        w_nstate     = LAYER_CONV1;
                        w_nphase     = PHASE_GAP;
                        w_layer_load = 1'b1;
                    end
                end
                LAYER_CONV1, LAYER_CONV2, LAYER_CONV3, LAYER_FCL1, LAYER_FCL2: begin
                    case (r_phase)
                        PHASE_GAP: w_nphase = PHASE_RUN;
                        PHASE_RUN: begin
                            if (iRd_DONE) begin
                                w_nphase     = PHASE_DRAIN;
                                w_drain_load = 1'b1;
                            end
                        end
                        PHASE_DRAIN: begin
                            if (w_drain_tc) begin
                                w_nphase = PHASE_GAP;
                                if (r_state == LAYER_FCL2) begin
                                    w_nstate = LAYER_IDLE;
                                    w_done   = 1'b1;
                                end else begin
                                    w_nstate     = next_layer(r_state);
                                    w_layer_load = 1'b1;
                                end
                            end
                        end
                        default: w_nphase = PHASE_GAP;
                    endcase
                end
                default: begin
                    w_nstate = LAYER_IDLE;
                    w_nphase = PHASE_GAP;
                end
            endcase
        end
    end

    // State register; outputs are registered from the next-state decode.
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            r_state       <= LAYER_IDLE;
            r_phase       <= PHASE_GAP;
            r_rd_en       <= 1'b0;
            r_layer_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_nstate;
            r_phase       <= w_nphase;
            r_rd_en       <= is_compute_layer(w_nstate) && (w_nphase == PHASE_RUN);
            r_layer_start <= is_compute_layer(w_nstate) && (w_nphase == PHASE_GAP);
            r_busy        <= (w_nstate != LAYER_IDLE);
            r_done        <= w_done;
            r_err         <= w_err;
        end
    end

    assign oSTATE       = r_state;
    assign oRd_EN       = r_rd_en;
    assign oLAYER_START = r_layer_start;
    assign oBUSY        = r_busy;
    assign oDONE        = r_done;
    assign oERR         = r_err;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// tb/tb_bnn_layer_sequencer.sv - self-checking bench for bnn_layer_sequencer
module tb_bnn_layer_sequencer;

    localparam int PD  = 4;
    localparam int TMO = 100;

    logic       iCLK = 1'b0;
    logic       iRSTn, iSTART, iABORT, iLOAD_DONE, iRd_DONE;
    logic [2:0] oSTATE;
    logic       oRd_EN, oLAYER_START, oBUSY, oDONE, oERR;

    bnn_layer_sequencer #(
        .PIPE_DRAIN (PD),
        .TIMEOUT    (16'(TMO))
    ) dut (
        .iCLK         (iCLK),
        .iRSTn        (iRSTn),
        .iSTART       (iSTART),
        .iABORT       (iABORT),
        .iLOAD_DONE   (iLOAD_DONE),
        .iRd_DONE     (iRd_DONE),
        .oSTATE       (oSTATE),
        .oRd_EN       (oRd_EN),
        .oLAYER_START (oLAYER_START),
        .oBUSY        (oBUSY),
        .oDONE        (oDONE),
        .oERR         (oERR)
    );

    always #5 iCLK = ~iCLK;

    // Reference model: layer 0 idle, 1 read, 2..6 compute; sub 0 gap, 1 run, 2 drain.
    int m_layer = 0, m_sub = 0, m_age = 0, m_run = 0, m_dl = 0;
    bit m_err = 1'b0, m_done = 1'b0;

    int n_chk = 0, n_pass = 0, n_cyc = 0;
    int n_ls, n_done, n_rden, n_lay, n_st3, t_gap, t_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n_cyc, got, exp);
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (!iRSTn) begin
            m_layer = 0; m_sub = 0; m_age = 0; m_run = 0; m_dl = 0; m_err = 1'b0;
        end else if (m_layer != 0 && iABORT) begin
            m_layer = 0; m_sub = 0;
        end else if (m_layer != 0 && m_age == TMO) begin
            m_layer = 0; m_sub = 0; m_err = 1'b1;
        end else if (m_layer == 0) begin
            if (iSTART && !iABORT) begin m_layer = 1; m_age = 1; m_err = 1'b0; end
        end else if (m_layer == 1) begin
            if (iLOAD_DONE) begin m_layer = 2; m_sub = 0; m_age = 1; end
            else m_age++;
        end else begin
            m_age++;
            case (m_sub)
                0: begin m_sub = 1; m_run = 1; end
                1: if (iRd_DONE) begin m_sub = 2; m_dl = PD; end else m_run++;
                default: begin
                    m_dl--;
                    if (m_dl == 0) begin
                        m_sub = 0;
                        if (m_layer == 6) begin m_layer = 0; m_done = 1'b1; end
                        else begin m_layer++; m_age = 1; end
                    end
                end
            endcase
        end
    endtask

    task automatic clear_stats();
        n_ls = 0; n_done = 0; n_rden = 0; n_lay = 0; n_st3 = 0; t_gap = 0; t_done = 0;
    endtask

    task automatic cycle();
        logic [7:0] exp;
        @(posedge iCLK);
        model_step();
        #1;
        n_cyc++;
        exp = {3'(m_layer), (m_layer >= 2 && m_sub == 1), (m_layer >= 2 && m_sub == 0),
               (m_layer != 0), m_done, m_err};
        check_eq("outs", {24'd0, oSTATE, oRd_EN, oLAYER_START, oBUSY, oDONE, oERR}, {24'd0, exp});
        if (oLAYER_START) n_ls++;
        if (oLAYER_START && oSTATE == 3'd6) t_gap = n_cyc;
        if (oDONE) begin n_done++; t_done = n_cyc; end
        if (oRd_EN) n_rden++;
        if (oSTATE >= 3'd2 && oSTATE <= 3'd6) n_lay++;
        if (oSTATE == 3'd3) n_st3++;
    endtask

    task automatic start_and_load();
        iSTART = 1'b1; cycle(); iSTART = 1'b0;
        iLOAD_DONE = 1'b1; cycle(); iLOAD_DONE = 1'b0;
    endtask

    // Runs layers until idle; iRd_DONE fires once RUN has lasted rd_at cycles.
    task automatic run_layers(input int rd_at, input int skip_layer, input bit rd_hold, input int budget);
        int k = 0;
        while (m_layer != 0 && k < budget) begin
            iRd_DONE = rd_hold || (m_layer >= 2 && m_sub == 1 && m_layer != skip_layer && m_run >= rd_at);
            cycle();
            k++;
        end
        iRd_DONE = 1'b0;
        check_eq("run_budget", 32'(k < budget), 32'd1);
    endtask

    task automatic advance_to(input int lay, input int run_min, input bit rd_hold, input int budget);
        int k = 0;
        while (!(m_layer == lay && m_sub == 1 && m_run >= run_min) && k < budget) begin
            iRd_DONE = rd_hold || (m_layer >= 2 && m_layer != lay && m_sub == 1 && m_run >= 2);
            cycle();
            k++;
        end
        check_eq("adv_budget", 32'(k < budget), 32'd1);
    endtask

    initial begin
        iRSTn = 1'b0; iSTART = 1'b1; iABORT = 1'b0; iLOAD_DONE = 1'b0; iRd_DONE = 1'b0;
        clear_stats();
        repeat (3) cycle();
        check_eq("rst_state", 32'(oSTATE), 32'd0);
        check_eq("rst_busy", 32'(oBUSY), 32'd0);
        iRSTn = 1'b1; iSTART = 1'b0;
        cycle();

        // Nominal walk: load 3 cycles after start, RUN lasts 11 cycles.
        clear_stats();
        iSTART = 1'b1; cycle(); iSTART = 1'b0;
        check_eq("nom_read", 32'(oSTATE), 32'd1);
        repeat (2) cycle();
        iLOAD_DONE = 1'b1; cycle(); iLOAD_DONE = 1'b0;
        check_eq("nom_conv1", 32'(oSTATE), 32'd2);
        run_layers(11, 0, 1'b0, 400);
        check_eq("nom_ls", 32'(n_ls), 32'd5);
        check_eq("nom_done", 32'(n_done), 32'd1);
        check_eq("nom_gap2done", 32'(t_done - t_gap), 32'd16);
        check_eq("nom_idle", 32'(oSTATE), 32'd0);

        // Minimum timing with iRd_DONE held high throughout.
        clear_stats();
        iRd_DONE = 1'b1;
        start_and_load();
        run_layers(1, 0, 1'b1, 200);
        check_eq("min_rden", 32'(n_rden), 32'd5);
        check_eq("min_laycyc", 32'(n_lay), 32'd30);
        check_eq("min_done", 32'(n_done), 32'd1);

        // Timeout in CONV2, then restart clears the error.
        clear_stats();
        start_and_load();
        run_layers(3, 3, 1'b0, 400);
        check_eq("tmo_conv2cyc", 32'(n_st3), 32'(TMO));
        check_eq("tmo_err", 32'(oERR), 32'd1);
        check_eq("tmo_nodone", 32'(n_done), 32'd0);
        iSTART = 1'b1; cycle(); iSTART = 1'b0;
        check_eq("tmo_errclr", 32'(oERR), 32'd0);
        iABORT = 1'b1; cycle(); iABORT = 1'b0;
        check_eq("abort_read", 32'(oSTATE), 32'd0);

        // Abort coincident with iRd_DONE in FCL1 RUN.
        clear_stats();
        start_and_load();
        advance_to(5, 1, 1'b1, 200);
        iABORT = 1'b1; iRd_DONE = 1'b1; cycle();
        iABORT = 1'b0; iRd_DONE = 1'b0;
        check_eq("abort_state", 32'(oSTATE), 32'd0);
        check_eq("abort_rden", 32'(oRd_EN), 32'd0);
        cycle();
        check_eq("abort_nodone", 32'(n_done), 32'd0);

        // Reset in the middle of CONV3 RUN, iSTART held during reset.
        clear_stats();
        start_and_load();
        advance_to(4, 3, 1'b0, 200);
        iRd_DONE = 1'b0; iRSTn = 1'b0; iSTART = 1'b1;
        cycle();
        check_eq("rstmid_outs", {24'd0, oSTATE, oRd_EN, oLAYER_START, oBUSY, oDONE, oERR}, 32'd0);
        cycle();
        iRSTn = 1'b1; iSTART = 1'b0;
        cycle();
        check_eq("rstmid_nostart", 32'(oSTATE), 32'd0);

        // Randomized traffic against the model; second half starves iRd_DONE.
        for (int i = 0; i < 3000; i++) begin
            iRSTn      = ($urandom_range(0, 199) != 0);
            iSTART     = ($urandom_range(0, 7) == 0);
            iLOAD_DONE = ($urandom_range(0, 3) == 0);
            if (i < 1500) begin
                iABORT   = ($urandom_range(0, 63) == 0);
                iRd_DONE = ($urandom_range(0, 5) == 0);
            end else begin
                iABORT   = ($urandom_range(0, 255) == 0);
                iRd_DONE = ($urandom_range(0, 199) == 0);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
